gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//  Gray-coded up/down counter for CDC pointers and rotary/position encoders. State is held in
//  Gray code and decoded to binary every cycle through a PrefixXor instance. Next state is
//  binary +/-1, re-encoded to Gray.
//  Sits directly upstream of consumers of Gray-to-binary decode. Its gray_o feeds sync stages;
//  its bin_o feeds local arithmetic.
// PARAMETERS
//  width    8  counter / code width in bits, >= 2
//  speed    0  PrefixXor structure passed through: 0 serial, 1 Brent-Kung, 2 Sklansky
//  saturate 0  0: wrap modulo 2**width; 1: hold at binary all-ones (up) or zero (down)
// PORTS
//  clk_i       in   1      clock, all state on rising edge
//  rst_ni      in   1      reset, synchronous, active-low
//  clear_i     in   1      synchronous clear to zero
//  load_i      in   1      load gray_o <= load_gray_i
//  load_gray_i in   width  load value, already Gray-coded
//  en_i        in   1      count enable
//  up_i        in   1      direction: 1 increment, 0 decrement (sampled only with en_i)
//  gray_o      out  width  current count, Gray code, registered (glitch-free for CDC)
//  bin_o       out  width  binary decode of gray_o, combinational from gray register
//  wrap_o      out  1      registered 1-cycle pulse: previous count step wrapped
//  sat_o       out  1      level: count at the saturation limit for current up_i (saturate=1 only)
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk edge): gray_q=0, wrap_q=0. Hence gray_o=0, bin_o=0, wrap_o=0.
//    Reset overrides all other inputs, including mid-count.
//  - Priority per edge: reset > clear_i > load_i > en_i > hold.
//  - clear_i: gray_q <= 0, wrap_q <= 0.
//  - load_i: gray_q <= load_gray_i, wrap_q <= 0. No validity check; any pattern is a legal Gray code.
//  - Decode: bin[i] = ^gray_q[width-1:i].
//    Realised as bin = rev(PrefixXor(rev(gray_q))). PrefixXor is LSB-first prefix, so the bit
//    reversal on input and output is mandatory.
//  - Count (en_i=1): nb = up_i ? bin+1 : bin-1, width-bit modulo arithmetic.
//    gray_q <= nb ^ (nb>>1). Exactly one bit of gray_o changes per count step.
//  - Wrap: wrap_q <= 1 when (up_i && bin=all-ones) || (!up_i && bin=0). Otherwise wrap_q <= 0.
//    Any non-counting cycle clears wrap_q.
//  - saturate=1: at the limit for the current direction, gray_q holds and wrap_q stays 0.
//    sat_o = (up_i ? bin=all-ones : bin=0). sat_o is tied 0 when saturate=0.
//  - Latency: gray_o/bin_o reflect clear/load/count 1 cycle after the enabling edge.
//    wrap_o pulses in the same cycle the wrapped value appears.
//  - clear_i with load_i: clear wins. load_i with en_i: load wins, no count applied.
//  - up_i is ignored when en_i=0. It still drives sat_o combinationally.
// STRUCTURE
//  - Package gray_pkg:
//    - function bin2gray(logic [W-1:0]).
//    - function bit_reverse.
//    - localparam SPEED_SERIAL/SPEED_BK/SPEED_SKLANSKY.
//  - Sub-module: one PrefixXor #(.width(width), .speed(speed)) instance for the decode.
//    Increment/decrement and re-encode stay inline. Only gray_q and wrap_q are registered.
// TESTING (width=4 unless noted; each scenario run for speed 0, 1, 2)
//  - Reset then 4x en_i=1, up_i=1 -> gray_o 0001,0011,0010,0110; bin_o=0100; wrap_o never high.
//  - Load 1000 (bin 15), then en up -> gray_o=0000, bin_o=0, wrap_o=1 for exactly 1 cycle.
//  - From 0, en down -> gray_o=1000, bin_o=1111, wrap_o=1. Next idle cycle -> wrap_o=0.
//  - saturate=1, load 1000, en up x3 -> gray_o stays 1000, sat_o=1, wrap_o=0.
//    Then up_i=0, en=1 -> gray_o=1001 (bin 14).
//  - clear_i, load_i and en_i together at count 0110 -> gray_o=0000.
//    load_i+en_i with load_gray_i=0101 -> gray_o=0101, not 0111.
//  - rst_ni low mid-count at 0110 -> next edge gray_o=0000, wrap_o=0.
//    Full 2**width up sweep (width 8): exactly 1 bit toggles per step, bin_o matches reference counter.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers and structure selectors for the Gray-code counter.
// Helpers work on a fixed MAX_W-wide vector; callers zero-extend in and size-cast out.
package gray_pkg;
    localparam int MAX_W = 64;
    localparam int SPEED_SERIAL = 0;
    localparam int SPEED_BK = 1;
    localparam int SPEED_SKLANSKY = 2;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Reverses the low w bits of v; the result lands in the low w bits.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (MAX_W - w);
    endfunction
endpackage

// File: rtl/gray_counter_prefix_xor.sv
// prefix_xor: LSB-first prefix XOR, y[i] = ^x[i:0], in serial, Brent-Kung or Sklansky form.
module prefix_xor
    import gray_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = SPEED_SERIAL
) (
    input  logic [width-1:0] x,
    output logic [width-1:0] y
);
    localparam int L = $clog2(width);

    generate
        if (speed == SPEED_BK) begin : g_bk
            // Stages 0..L are the up-sweep, L..2L-1 the down-sweep.
            logic t [0:2*L-1][0:width-1];
            for (genvar i = 0; i < width; i++) begin : g_in
                assign t[0][i] = x[i];
                assign y[i] = t[2*L-1][i];
            end
            for (genvar l = 0; l < L; l++) begin : g_up
                for (genvar i = 0; i < width; i++) begin : g_b
                    if ((i + 1) % (2 << l) == 0) begin : g_op
                        assign t[l+1][i] = t[l][i] ^ t[l][i-(1<<l)];
                    end else begin : g_pass
                        assign t[l+1][i] = t[l][i];
                    end
                end
            end
            for (genvar d = 0; d < L - 1; d++) begin : g_dn
                localparam int s = L - 2 - d;
                for (genvar i = 0; i < width; i++) begin : g_b
                    if (((i + 1) % (2 << s) == (1 << s)) && (i >= (2 << s))) begin : g_op
                        assign t[L+d+1][i] = t[L+d][i] ^ t[L+d][i-(1<<s)];
                    end else begin : g_pass
                        assign t[L+d+1][i] = t[L+d][i];
                    end
                end
            end
        end else if (speed == SPEED_SKLANSKY) begin : g_sk
            logic t [0:L][0:width-1];
            for (genvar i = 0; i < width; i++) begin : g_in
                assign t[0][i] = x[i];
                assign y[i] = t[L][i];
            end
            for (genvar l = 0; l < L; l++) begin : g_lvl
                for (genvar i = 0; i < width; i++) begin : g_b
                    if (((i >> l) & 1) == 1) begin : g_op
                        assign t[l+1][i] = t[l][i] ^ t[l][((i>>l)<<l)-1];
                    end else begin : g_pass
                        assign t[l+1][i] = t[l][i];
                    end
                end
            end
        end else begin : g_serial
            logic c [0:width-1];
            assign c[0] = x[0];
            assign y[0] = c[0];
            for (genvar i = 1; i < width; i++) begin : g_b
                assign c[i] = c[i-1] ^ x[i];
                assign y[i] = c[i];
            end
        end
    endgenerate
endmodule

// File: rtl/gray_counter.sv
// gray_counter: Gray-coded up/down counter with registered Gray output, decoded binary,
// wrap pulse and optional saturation at the direction limit.
module gray_counter
    import gray_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = SPEED_SERIAL,
    parameter int saturate = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [width-1:0] load_gray_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [width-1:0] gray_o,
    output logic [width-1:0] bin_o,
    output logic             wrap_o,
    output logic             sat_o
);
    logic [width-1:0] gray_q;
    logic             wrap_q;
    logic [width-1:0] gray_rev;
    logic [width-1:0] pre_rev;
    logic [width-1:0] bin;
    logic [width-1:0] nb;
    logic [width-1:0] next_gray;
    logic             at_lim;
    logic             hold;

    // PrefixXor accumulates from the LSB, decode needs it from the MSB: reverse both sides.
    assign gray_rev = width'(bit_reverse(MAX_W'(gray_q), width));

    prefix_xor #(.width(width), .speed(speed)) u_decode (
        .x(gray_rev),
        .y(pre_rev)
    );

    assign bin = width'(bit_reverse(MAX_W'(pre_rev), width));
    assign nb = up_i ? bin + width'(1) : bin - width'(1);
    assign next_gray = width'(bin2gray(MAX_W'(nb)));
    assign at_lim = up_i ? (bin == '1) : (bin == '0);
    assign hold = (saturate != 0) && at_lim;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (clear_i) begin
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (load_i) begin
            gray_q <= load_gray_i;
            wrap_q <= 1'b0;
        end else if (en_i) begin
            gray_q <= hold ? gray_q : next_gray;
            wrap_q <= at_lim && !hold;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign gray_o = gray_q;
    assign bin_o = bin;
    assign wrap_o = wrap_q;
    assign sat_o = hold;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: nine counter configurations driven in lockstep and checked against
// an arithmetic reference model, a directed vector table and multi-cycle corner sequences.
module tb_gray_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clear, load, en, up;
    logic [7:0] ld;
    logic [7:0] g_o [9];
    logic [7:0] b_o [9];
    logic w_o [9];
    logic s_o [9];
    int checks = 0;
    int errors = 0;
    int mb [9];
    bit mw [9];

    // k 0..2: width 4 wrap, k 3..5: width 4 saturate, k 6..8: width 8 wrap; speed = k % 3
    for (genvar k = 0; k < 9; k++) begin : g_dut
        localparam int W = (k < 6) ? 4 : 8;
        logic [W-1:0] g, b;
        logic w, s;
        gray_counter #(.width(W), .speed(k % 3), .saturate((k >= 3 && k < 6) ? 1 : 0)) dut (
            .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load),
            .load_gray_i(ld[W-1:0]), .en_i(en), .up_i(up),
            .gray_o(g), .bin_o(b), .wrap_o(w), .sat_o(s)
        );
        assign g_o[k] = 8'(g);
        assign b_o[k] = 8'(b);
        assign w_o[k] = w;
        assign s_o[k] = s;
    end

    function automatic int mask_of(int k);
        return (k < 6) ? 15 : 255;
    endfunction

    function automatic bit sat_of(int k);
        return k >= 3 && k < 6;
    endfunction

    function automatic int g2b(int g);
        int b = g;
        for (int s = 1; s < 8; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    task automatic chk(string name, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 9; k++) begin
            int m = mask_of(k);
            bit lim = up ? (mb[k] == m) : (mb[k] == 0);
            if (!rst_n || clear) begin
                mb[k] = 0;
                mw[k] = 0;
            end else if (load) begin
                mb[k] = g2b(int'(ld) & m);
                mw[k] = 0;
            end else if (en) begin
                if (sat_of(k) && lim) mw[k] = 0;
                else begin
                    mw[k] = lim;
                    mb[k] = (mb[k] + (up ? 1 : -1)) & m;
                end
            end else mw[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 9; k++) begin
            int m = mask_of(k);
            bit es = sat_of(k) && (up ? (mb[k] == m) : (mb[k] == 0));
            chk("gray", k, int'(g_o[k]), mb[k] ^ (mb[k] >> 1));
            chk("bin", k, int'(b_o[k]), mb[k]);
            chk("wrap", k, int'(w_o[k]), int'(mw[k]));
            chk("sat", k, int'(s_o[k]), int'(es));
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set(bit r, bit c, bit l, logic [7:0] lg, bit e, bit u);
        rst_n = !r;
        clear = c;
        load = l;
        ld = lg;
        en = e;
        up = u;
    endtask

    typedef struct {
        bit rst, clr, ld, en, up;
        logic [3:0] lg, eg, eb;
        bit ew;
    } vec_t;
    vec_t tbl [16];
    logic [7:0] prev [9];
    int ref_cnt;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 4'h0, 4'b0000, 4'd0, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 4'h0, 4'b0001, 4'd1, 0};
        tbl[2]  = '{0, 0, 0, 1, 1, 4'h0, 4'b0011, 4'd2, 0};
        tbl[3]  = '{0, 0, 0, 1, 1, 4'h0, 4'b0010, 4'd3, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 4'h0, 4'b0110, 4'd4, 0};
        tbl[5]  = '{0, 0, 1, 0, 1, 4'b1000, 4'b1000, 4'd15, 0};
        tbl[6]  = '{0, 0, 0, 1, 1, 4'h0, 4'b0000, 4'd0, 1};
        tbl[7]  = '{0, 0, 0, 0, 1, 4'h0, 4'b0000, 4'd0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 4'h0, 4'b1000, 4'd15, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 4'h0, 4'b1000, 4'd15, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 4'b0110, 4'b0110, 4'd4, 0};
        tbl[11] = '{0, 1, 1, 1, 1, 4'b0101, 4'b0000, 4'd0, 0};
        tbl[12] = '{0, 0, 1, 1, 1, 4'b0101, 4'b0101, 4'd6, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 4'h0, 4'b0100, 4'd7, 0};
        tbl[14] = '{0, 0, 1, 0, 1, 4'b0110, 4'b0110, 4'd4, 0};
        tbl[15] = '{1, 0, 1, 1, 1, 4'b1000, 4'b0000, 4'd0, 0};
        set(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            set(tbl[i].rst, tbl[i].clr, tbl[i].ld, 8'(tbl[i].lg), tbl[i].en, tbl[i].up);
            cyc();
            for (int k = 0; k < 3; k++) begin
                chk("tbl_gray", k, int'(g_o[k]), int'(tbl[i].eg));
                chk("tbl_bin", k, int'(b_o[k]), int'(tbl[i].eb));
                chk("tbl_wrap", k, int'(w_o[k]), int'(tbl[i].ew));
            end
        end
        // saturation at the top, then step back down
        set(0, 0, 1, 8'b1000, 0, 1);
        cyc();
        for (int n = 0; n < 3; n++) begin
            set(0, 0, 0, 8'h00, 1, 1);
            cyc();
            for (int k = 3; k < 6; k++) begin
                chk("sat_gray", k, int'(g_o[k]), 8);
                chk("sat_flag", k, int'(s_o[k]), 1);
                chk("sat_wrap", k, int'(w_o[k]), 0);
            end
        end
        set(0, 0, 0, 8'h00, 1, 0);
        cyc();
        for (int k = 3; k < 6; k++) begin
            chk("sat_down_gray", k, int'(g_o[k]), 9);
            chk("sat_down_bin", k, int'(b_o[k]), 14);
        end
        // full width-8 up sweep
        set(1, 0, 0, 8'h00, 0, 1);
        cyc();
        ref_cnt = 0;
        for (int n = 0; n < 256; n++) begin
            for (int k = 6; k < 9; k++) prev[k] = g_o[k];
            set(0, 0, 0, 8'h00, 1, 1);
            cyc();
            ref_cnt = (ref_cnt + 1) % 256;
            for (int k = 6; k < 9; k++) begin
                chk("sweep_onebit", k, $countones(prev[k] ^ g_o[k]), 1);
                chk("sweep_bin", k, int'(b_o[k]), ref_cnt);
            end
        end
        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            set(($urandom % 40) == 0, ($urandom % 20) == 0, ($urandom % 8) == 0,
                8'($urandom), ($urandom % 4) != 0, 1'($urandom));
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
